// File: rtl/multi_list_linked_list.sv
`default_nettype none
// ============================================================================
//  Module   : multi_list_linked_list
//  Brief    : NUM_LISTS singly linked lists sharing one MAX_NODE node pool,
//             with index-, value- and end-based operations.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_list_linked_list #(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_NODE   = 16,
    parameter  int NUM_LISTS  = 4,
    localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1),
    localparam int LIST_WIDTH = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            op_start,
    input  logic [2:0]                      op,
    input  logic [LIST_WIDTH-1:0]           list_sel,
    input  logic [ADDR_WIDTH-1:0]           index_in,
    input  logic [DATA_WIDTH-1:0]           data_in,
    output logic                            busy,
    output logic                            op_done,
    output logic                            fault,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic [ADDR_WIDTH-1:0]           node_addr_out,
    output logic [NUM_LISTS*ADDR_WIDTH-1:0] lengths,
    output logic [NUM_LISTS-1:0]            list_empty,
    output logic [ADDR_WIDTH-1:0]           free_count,
    output logic                            full
);

    localparam int                    c_LIST_DEPTH = 1 << LIST_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_NULL       = ADDR_WIDTH'(MAX_NODE);
    localparam logic [ADDR_WIDTH-1:0] c_ONE        = ADDR_WIDTH'(1);

    localparam logic [2:0] c_OP_READ_IDX   = 3'd0;
    localparam logic [2:0] c_OP_INSERT_IDX = 3'd1;
    localparam logic [2:0] c_OP_DELETE_VAL = 3'd2;
    localparam logic [2:0] c_OP_DELETE_IDX = 3'd3;
    localparam logic [2:0] c_OP_PUSH_FRONT = 3'd4;
    localparam logic [2:0] c_OP_POP_FRONT  = 3'd5;
    localparam logic [2:0] c_OP_PUSH_BACK  = 3'd6;
    localparam logic [2:0] c_OP_RESERVED   = 3'd7;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WALK  = 3'd1;
    localparam logic [2:0] c_ST_LINK  = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_FAULT = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            r_op;
    logic [LIST_WIDTH-1:0] r_list;
    logic [ADDR_WIDTH-1:0] r_tgt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [ADDR_WIDTH-1:0] r_prev;
    logic [DATA_WIDTH-1:0] r_key;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [ADDR_WIDTH-1:0] r_node_addr;
    logic [ADDR_WIDTH-1:0] r_free;

    // One extra slot at index NULL lets pointer lookups stay in range.
    logic [DATA_WIDTH-1:0] r_mem  [MAX_NODE+1];
    logic [ADDR_WIDTH-1:0] r_next [MAX_NODE+1];
    logic [MAX_NODE-1:0]   r_valid;
    logic [ADDR_WIDTH-1:0] r_head [c_LIST_DEPTH];
    logic [ADDR_WIDTH-1:0] r_tail [c_LIST_DEPTH];
    logic [ADDR_WIDTH-1:0] r_len  [c_LIST_DEPTH];

    logic [ADDR_WIDTH-1:0] w_alloc;
    logic [ADDR_WIDTH-1:0] w_len;
    logic [ADDR_WIDTH-1:0] w_head;
    logic [ADDR_WIDTH-1:0] w_tail;
    logic [ADDR_WIDTH-1:0] w_tgt;
    logic [ADDR_WIDTH-1:0] w_cur_next;
    logic                  w_full;
    logic                  w_list_bad;
    logic                  w_needs_node;
    logic                  w_needs_item;
    logic                  w_idx_bound;
    logic                  w_imm_fault;
    logic                  w_head_hit;
    logic                  w_direct;
    logic                  w_walk_hit;
    logic                  w_walk_miss;

    function automatic logic f_is_ins(input logic [2:0] i_op);
        return (i_op == c_OP_INSERT_IDX) || (i_op == c_OP_PUSH_FRONT) ||
               (i_op == c_OP_PUSH_BACK);
    endfunction

    function automatic logic f_is_del(input logic [2:0] i_op);
        return (i_op == c_OP_DELETE_VAL) || (i_op == c_OP_DELETE_IDX) ||
               (i_op == c_OP_POP_FRONT);
    endfunction

    // Lowest-index free node wins.
    always_comb begin
        w_alloc = c_NULL;
        for (int i = MAX_NODE - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc = ADDR_WIDTH'(i);
            end
        end
    end

    always_comb begin
        w_len        = r_len[list_sel];
        w_head       = r_head[list_sel];
        w_tail       = r_tail[list_sel];
        w_full       = (r_free == '0);
        w_list_bad   = (int'(list_sel) >= NUM_LISTS);
        w_needs_node = f_is_ins(op);
        w_needs_item = f_is_del(op) || (op == c_OP_READ_IDX);
        w_idx_bound  = ((op == c_OP_READ_IDX) || (op == c_OP_DELETE_IDX)) &&
                       (index_in >= w_len);
        w_imm_fault  = (op == c_OP_RESERVED) || w_list_bad ||
                       (w_needs_node && w_full) ||
                       (w_needs_item && (w_len == '0)) || w_idx_bound;
        // Inserting past the end clamps to an append.
        if ((op == c_OP_INSERT_IDX) && (index_in >= w_len)) begin
            w_tgt = w_len;
        end else begin
            w_tgt = index_in;
        end
        w_head_hit = (r_mem[w_head] == data_in);
        w_direct   = (op == c_OP_PUSH_FRONT) || (op == c_OP_POP_FRONT) ||
                     (((op == c_OP_READ_IDX) || (op == c_OP_INSERT_IDX) ||
                       (op == c_OP_DELETE_IDX)) && (w_tgt == '0)) ||
                     ((op == c_OP_DELETE_VAL) && w_head_hit);
    end

    always_comb begin
        w_cur_next  = r_next[r_cur];
        w_walk_miss = (r_op == c_OP_DELETE_VAL) && (r_cur == c_NULL);
        if (r_op == c_OP_DELETE_VAL) begin
            w_walk_hit = (r_cur != c_NULL) && (r_mem[r_cur] == r_key);
        end else begin
            w_walk_hit = (r_cnt == r_tgt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_op        <= '0;
            r_list      <= '0;
            r_tgt       <= '0;
            r_cnt       <= '0;
            r_cur       <= c_NULL;
            r_prev      <= c_NULL;
            r_key       <= '0;
            r_data_out  <= '0;
            r_node_addr <= '0;
            r_free      <= ADDR_WIDTH'(MAX_NODE);
            r_valid     <= '0;
            for (int i = 0; i <= MAX_NODE; i++) begin
                r_next[i] <= c_NULL;
            end
            for (int l = 0; l < c_LIST_DEPTH; l++) begin
                r_head[l] <= c_NULL;
                r_tail[l] <= c_NULL;
                r_len[l]  <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (op_start) begin
                        r_op   <= op;
                        r_list <= list_sel;
                        r_key  <= data_in;
                        r_tgt  <= w_tgt;
                        if (w_imm_fault) begin
                            r_state <= c_ST_FAULT;
                        end else if (op == c_OP_PUSH_BACK) begin
                            r_cur   <= c_NULL;
                            r_prev  <= w_tail;
                            r_cnt   <= '0;
                            r_state <= c_ST_LINK;
                        end else if (w_direct) begin
                            r_cur   <= w_head;
                            r_prev  <= c_NULL;
                            r_cnt   <= '0;
                            r_state <= c_ST_LINK;
                        end else begin
                            // Head already examined; the walk starts at position 1.
                            r_cur   <= r_next[w_head];
                            r_prev  <= w_head;
                            r_cnt   <= c_ONE;
                            r_state <= c_ST_WALK;
                        end
                    end
                end
                c_ST_WALK: begin
                    if (w_walk_miss) begin
                        r_state <= c_ST_FAULT;
                    end else if (w_walk_hit) begin
                        r_state <= c_ST_LINK;
                    end else begin
                        r_prev <= r_cur;
                        r_cur  <= w_cur_next;
                        r_cnt  <= r_cnt + c_ONE;
                    end
                end
                c_ST_LINK: begin
                    if (r_op == c_OP_READ_IDX) begin
                        r_data_out  <= r_mem[r_cur];
                        r_node_addr <= r_cur;
                    end else if (f_is_ins(r_op)) begin
                        // New node goes between prev and cur.
                        for (int i = 0; i < MAX_NODE; i++) begin
                            if (ADDR_WIDTH'(i) == w_alloc) begin
                                r_valid[i] <= 1'b1;
                            end
                        end
                        r_next[w_alloc] <= r_cur;
                        if (r_prev == c_NULL) begin
                            r_head[r_list] <= w_alloc;
                        end else begin
                            r_next[r_prev] <= w_alloc;
                        end
                        if (r_cur == c_NULL) begin
                            r_tail[r_list] <= w_alloc;
                        end
                        r_len[r_list] <= r_len[r_list] + c_ONE;
                        r_free        <= r_free - c_ONE;
                    end else begin
                        for (int i = 0; i < MAX_NODE; i++) begin
                            if (ADDR_WIDTH'(i) == r_cur) begin
                                r_valid[i] <= 1'b0;
                            end
                        end
                        r_next[r_cur] <= c_NULL;
                        if (r_prev == c_NULL) begin
                            r_head[r_list] <= w_cur_next;
                        end else begin
                            r_next[r_prev] <= w_cur_next;
                        end
                        if (r_cur == r_tail[r_list]) begin
                            r_tail[r_list] <= r_prev;
                        end
                        r_len[r_list] <= r_len[r_list] - c_ONE;
                        r_free        <= r_free + c_ONE;
                        r_data_out    <= r_mem[r_cur];
                        r_node_addr   <= r_cur;
                    end
                    r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                c_ST_FAULT: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Payload RAM carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if ((r_state == c_ST_LINK) && f_is_ins(r_op)) begin
            r_mem[w_alloc] <= r_key;
        end
    end

    assign busy          = (r_state != c_ST_IDLE);
    assign op_done       = (r_state == c_ST_DONE) || (r_state == c_ST_FAULT);
    assign fault         = (r_state == c_ST_FAULT);
    assign data_out      = r_data_out;
    assign node_addr_out = r_node_addr;
    assign free_count    = r_free;
    assign full          = (r_free == '0);

    generate
        for (genvar g = 0; g < NUM_LISTS; g++) begin : g_status
            assign lengths[g*ADDR_WIDTH +: ADDR_WIDTH] = r_len[g];
            assign list_empty[g]                       = (r_len[g] == '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_list_linked_list.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_list_linked_list
//  Brief    : Directed self-checking bench with a list model and scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_list_linked_list;

    localparam int DW = 8;
    localparam int MN = 16;
    localparam int NL = 4;
    localparam int AW = 5;
    localparam int LW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           op_start;
    logic [2:0]     op;
    logic [LW-1:0]  list_sel;
    logic [AW-1:0]  index_in;
    logic [DW-1:0]  data_in;
    logic           busy;
    logic           op_done;
    logic           fault;
    logic [DW-1:0]  data_out;
    logic [AW-1:0]  node_addr_out;
    logic [NL*AW-1:0] lengths;
    logic [NL-1:0]  list_empty;
    logic [AW-1:0]  free_count;
    logic           full;

    always #5 clk = ~clk;

    multi_list_linked_list #(
        .DATA_WIDTH (DW),
        .MAX_NODE   (MN),
        .NUM_LISTS  (NL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .op_start      (op_start),
        .op            (op),
        .list_sel      (list_sel),
        .index_in      (index_in),
        .data_in       (data_in),
        .busy          (busy),
        .op_done       (op_done),
        .fault         (fault),
        .data_out      (data_out),
        .node_addr_out (node_addr_out),
        .lengths       (lengths),
        .list_empty    (list_empty),
        .free_count    (free_count),
        .full          (full)
    );

    typedef struct {
        bit          flt;
        int          lat;
        logic [7:0]  d;
        logic [4:0]  a;
    } exp_t;

    exp_t  sbq[$];
    string tagq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: per-list ordered node addresses plus pool state.
    int         mlen [NL];
    int         mlst [NL][MN];
    bit         mval [MN];
    logic [7:0] mdat [MN];
    int         mfree;
    int         mdo;
    int         mda;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int l = 0; l < NL; l++) mlen[l] = 0;
        for (int i = 0; i < MN; i++) mval[i] = 1'b0;
        mfree = MN;
        mdo   = 0;
        mda   = 0;
    endtask

    task automatic m_insert(input int l, input int k, input logic [7:0] d);
        int n;
        n = 0;
        while (mval[n]) n++;
        mval[n] = 1'b1;
        mdat[n] = d;
        mfree--;
        for (int i = mlen[l]; i > k; i--) mlst[l][i] = mlst[l][i-1];
        mlst[l][k] = n;
        mlen[l]++;
    endtask

    task automatic m_remove(input int l, input int k);
        int n;
        n = mlst[l][k];
        mval[n] = 1'b0;
        mfree++;
        mdo = int'(mdat[n]);
        mda = n;
        for (int i = k; i < mlen[l] - 1; i++) mlst[l][i] = mlst[l][i+1];
        mlen[l]--;
    endtask

    task automatic chk_status(input string tag);
        logic [NL*AW-1:0] el;
        logic [NL-1:0]    ee;
        for (int l = 0; l < NL; l++) begin
            el[l*AW +: AW] = AW'(mlen[l]);
            ee[l]          = (mlen[l] == 0);
        end
        chk({tag, ".lengths"}, 64'(lengths), 64'(el));
        chk({tag, ".empty"},   64'(list_empty), 64'(ee));
        chk({tag, ".free"},    64'(free_count), 64'(mfree));
        chk({tag, ".full"},    64'(full), 64'(mfree == 0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".busy"},  64'(busy), 64'd0);
        chk({tag, ".done"},  64'(op_done), 64'd0);
        chk({tag, ".fault"}, 64'(fault), 64'd0);
        chk({tag, ".dout"},  64'(data_out), 64'd0);
        chk({tag, ".addr"},  64'(node_addr_out), 64'd0);
        chk({tag, ".lengths"}, 64'(lengths), 64'd0);
        chk({tag, ".empty"}, 64'(list_empty), 64'hF);
        chk({tag, ".free"},  64'(free_count), 64'd16);
        chk({tag, ".full"},  64'(full), 64'd0);
    endtask

    // Predicts the op against the model, drives it, then checks at op_done.
    task automatic do_op(input string tag, input logic [2:0] o, input int l,
                         input int idx, input logic [7:0] d, input bit poke);
        exp_t  e;
        exp_t  g;
        string gt;
        int    len;
        int    k;
        int    p;
        int    lat;
        bit    nn;
        bit    ni;
        len   = mlen[l];
        e.flt = 1'b0;
        e.lat = 1;
        nn    = (o == 3'd1) || (o == 3'd4) || (o == 3'd6);
        ni    = (o == 3'd0) || (o == 3'd2) || (o == 3'd3) || (o == 3'd5);
        if ((o == 3'd7) || (nn && mfree == 0) || (ni && len == 0) ||
            (((o == 3'd0) || (o == 3'd3)) && idx >= len)) begin
            e.flt = 1'b1;
            e.lat = 0;
        end else begin
            case (o)
                3'd0: begin
                    e.lat = 1 + idx;
                    mda   = mlst[l][idx];
                    mdo   = int'(mdat[mda]);
                end
                3'd1: begin
                    k     = (idx > len) ? len : idx;
                    e.lat = 1 + k;
                    m_insert(l, k, d);
                end
                3'd2: begin
                    p = -1;
                    for (int i = 0; i < len; i++)
                        if (p < 0 && mdat[mlst[l][i]] == d) p = i;
                    if (p < 0) begin
                        e.flt = 1'b1;
                        e.lat = len;
                    end else begin
                        e.lat = 1 + p;
                        m_remove(l, p);
                    end
                end
                3'd3: begin
                    e.lat = 1 + idx;
                    m_remove(l, idx);
                end
                3'd4: m_insert(l, 0, d);
                3'd5: m_remove(l, 0);
                default: m_insert(l, len, d);
            endcase
        end
        e.d = 8'(mdo);
        e.a = 5'(mda);
        sbq.push_back(e);
        tagq.push_back(tag);

        @(negedge clk);
        for (int t = 0; busy && t < 100; t++) @(negedge clk);
        op_start = 1'b1;
        op       = o;
        list_sel = LW'(l);
        index_in = AW'(idx);
        data_in  = d;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        op       = 3'($urandom);
        list_sel = LW'($urandom);
        index_in = AW'($urandom);
        data_in  = 8'($urandom);
        lat = 0;
        while (!op_done && lat < 64) begin
            if (poke && lat == 1) begin
                op_start = 1'b1;
                op       = 3'd6;
                list_sel = LW'(l);
                data_in  = 8'h5A;
            end else begin
                op_start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        op_start = 1'b0;
        g  = sbq.pop_front();
        gt = tagq.pop_front();
        chk({gt, ".seen_done"}, 64'(op_done), 64'd1);
        chk({gt, ".latency"},   64'(lat), 64'(g.lat));
        chk({gt, ".fault"},     64'(fault), 64'(g.flt));
        chk({gt, ".dout"},      64'(data_out), 64'(g.d));
        chk({gt, ".addr"},      64'(node_addr_out), 64'(g.a));
        chk({gt, ".busy"},      64'(busy), 64'd1);
        chk_status(gt);
        @(posedge clk);
        #1;
        chk({gt, ".pulse"}, 64'(op_done), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        op_start = 1'b0;
        op       = '0;
        list_sel = '0;
        index_in = '0;
        data_in  = '0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset("reset");

        do_op("pb_a1", 3'd6, 0, 0, 8'hA1, 1'b0);
        do_op("pb_a2", 3'd6, 0, 0, 8'hA2, 1'b0);
        do_op("pb_a3", 3'd6, 0, 0, 8'hA3, 1'b0);
        do_op("pf_b0", 3'd4, 2, 0, 8'hB0, 1'b0);
        do_op("rd_l0_2", 3'd0, 0, 2, 8'h00, 1'b0);
        do_op("di_l0_1", 3'd3, 0, 1, 8'h00, 1'b0);
        do_op("ins_l1_5", 3'd1, 1, 5, 8'hC1, 1'b0);
        chk("reuse_node1", 64'(node_addr_out), 64'd1);
        do_op("rd_l0_0", 3'd0, 0, 0, 8'h00, 1'b0);
        do_op("rd_l0_1", 3'd0, 0, 1, 8'h00, 1'b0);
        do_op("dv_absent", 3'd2, 0, 0, 8'hEE, 1'b0);
        do_op("pop_empty", 3'd5, 3, 0, 8'h00, 1'b0);
        do_op("op7", 3'd7, 0, 0, 8'h00, 1'b0);
        do_op("rd_oob", 3'd0, 0, 2, 8'h00, 1'b0);

        do_op("pb_a4", 3'd6, 0, 0, 8'hA4, 1'b0);
        do_op("dv_a3_mid", 3'd2, 0, 0, 8'hA3, 1'b1);
        do_op("di_tail", 3'd3, 0, 1, 8'h00, 1'b0);
        do_op("ins_app", 3'd1, 0, 7, 8'hD1, 1'b0);
        do_op("ins_mid", 3'd1, 0, 1, 8'hD0, 1'b0);
        do_op("rd_l0_2b", 3'd0, 0, 2, 8'h00, 1'b0);
        do_op("dv_head", 3'd2, 2, 0, 8'hB0, 1'b0);
        do_op("pb_b1", 3'd6, 2, 0, 8'hB1, 1'b0);
        do_op("rd_l2_0", 3'd0, 2, 0, 8'h00, 1'b0);

        while (mfree > 0) do_op("fill", 3'd6, 1, 0, 8'(8'h10 + mfree), 1'b0);
        do_op("pb_full", 3'd6, 1, 0, 8'h77, 1'b0);
        do_op("ins_full", 3'd1, 2, 0, 8'h78, 1'b0);
        do_op("pop_l0", 3'd5, 0, 0, 8'h00, 1'b0);
        chk("pop_a1", 64'(data_out), 64'hA1);
        do_op("dv_far", 3'd2, 1, 0, 8'h13, 1'b0);
        do_op("rd_l1_6", 3'd0, 1, 6, 8'h00, 1'b0);

        @(negedge clk);
        op_start = 1'b1;
        op       = 3'd0;
        list_sel = 2'd1;
        index_in = 5'd8;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("walk.busy", 64'(busy), 64'd1);
        chk("walk.done", 64'(op_done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_hold.done", 64'(op_done), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        do_op("post_rst_pb", 3'd6, 3, 0, 8'hE1, 1'b0);
        do_op("post_rst_rd", 3'd0, 3, 0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
